// File: rtl/mem_bus_arbiter_if.sv
// Avalon-MM link bundle: one master-to-slave connection with a 32-bit data path.
// The arbiter takes two of these as slave ports and drives one as a master port.
interface mem_bus_arbiter_if #(
    parameter int AW = 32
);
    logic [AW-1:0] address;
    logic          read;
    logic          write;
    logic [31:0]   writedata;
    logic [3:0]    byteenable;
    logic [31:0]   readdata;
    logic          waitrequest;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, waitrequest
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter onto one Avalon-MM slave (m0 = fetch, m1 = load/store),
// with a registered grant and a per-transfer watchdog that aborts hung slave transfers.
module mem_bus_arbiter #(
    parameter int TIMEOUT = 256,
    parameter int AW      = 32
) (
    input  logic                clk,
    input  logic                reset,
    mem_bus_arbiter_if.slave    m0,
    mem_bus_arbiter_if.slave    m1,
    mem_bus_arbiter_if.master   s,
    output logic                bus_error,
    output logic [1:0]          grant
);
    localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          last_q, last_d;       // 0 = m0 served last, 1 = m1
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          bus_error_q, bus_error_d;

    logic          req0, req1;
    logic          own;
    logic [AW-1:0] o_addr;
    logic          o_rd, o_wr;
    logic [31:0]   o_wdata;
    logic [3:0]    o_be;
    logic          o_wait;
    logic [31:0]   o_rdata;
    logic          abort;

    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;

    // Owner-side view of whichever master holds the bus.
    always_comb begin
        own     = (state_q == OWN1);
        o_addr  = own ? m1.address    : m0.address;
        o_rd    = own ? m1.read       : m0.read;
        o_wr    = own ? m1.write      : m0.write;
        o_wdata = own ? m1.writedata  : m0.writedata;
        o_be    = own ? m1.byteenable : m0.byteenable;
        abort   = (TIMEOUT > 0) && s.waitrequest && (wait_cnt_q == CW'(LAST));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            wait_cnt_q  <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            wait_cnt_q  <= wait_cnt_d;
            bus_error_q <= bus_error_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        wait_cnt_d     = wait_cnt_q;
        bus_error_d    = bus_error_q;
        s.address      = '0;
        s.read         = 1'b0;
        s.write        = 1'b0;
        s.writedata    = '0;
        s.byteenable   = '0;
        grant          = 2'b00;
        o_wait         = 1'b1;
        o_rdata        = '0;
        m0.waitrequest = 1'b1;
        m0.readdata    = '0;
        m1.waitrequest = 1'b1;
        m1.readdata    = '0;

        case (state_q)
            IDLE: begin
                wait_cnt_d = '0;
                if (req0 && req1)
                    state_d = last_q ? OWN0 : OWN1;
                else if (req0)
                    state_d = OWN0;
                else if (req1)
                    state_d = OWN1;
            end

            OWN0, OWN1: begin
                grant        = own ? 2'b10 : 2'b01;
                s.address    = o_addr;
                s.writedata  = o_wdata;
                s.byteenable = o_be;
                // A simultaneous read+write is treated as a write.
                s.write      = o_wr;
                s.read       = o_rd & ~o_wr;
                o_wait       = s.waitrequest;
                o_rdata      = s.readdata;

                if (!(o_rd | o_wr)) begin
                    // Master withdrew mid-transfer; fairness state is left alone.
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else if (!s.waitrequest) begin
                    state_d    = IDLE;
                    last_d     = own;
                    wait_cnt_d = '0;
                end else if (abort) begin
                    s.read      = 1'b0;
                    s.write     = 1'b0;
                    o_wait      = 1'b0;
                    o_rdata     = '0;
                    bus_error_d = 1'b1;
                    state_d     = IDLE;
                    last_d      = own;
                    wait_cnt_d  = '0;
                end else if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end

                if (own) begin
                    m1.waitrequest = o_wait;
                    m1.readdata    = o_rdata;
                end else begin
                    m0.waitrequest = o_wait;
                    m0.readdata    = o_rdata;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus_error = bus_error_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: queue scoreboard for read data and slave-side writes,
// plus cycle counters and direct checks for grant order, stall timing, watchdog and async reset.
module tb_mem_bus_arbiter;
    localparam logic [31:0] KEY = 32'h5A5A_A5A5;

    logic       clk;
    logic       rst;
    logic       bus_error;
    logic [1:0] grant;

    mem_bus_arbiter_if #(.AW(32)) m0_if ();
    mem_bus_arbiter_if #(.AW(32)) m1_if ();
    mem_bus_arbiter_if #(.AW(32)) s_if ();

    mem_bus_arbiter #(.TIMEOUT(8), .AW(32)) dut (
        .clk       (clk),
        .reset     (rst),
        .m0        (m0_if),
        .m1        (m1_if),
        .s         (s_if),
        .bus_error (bus_error),
        .grant     (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0]  q0[$];
    logic [31:0]  q1[$];
    logic [67:0]  sq[$];
    logic [15:0]  ord_bits;
    int           ord_n;
    int           n_g0, n_g1, n_sw, n_w1, n_m0go;

    // Slave model: fixed wait count per transfer, or stuck in wait.
    int slv_wait;
    bit stuck;
    int wcnt;
    assign s_if.waitrequest = stuck | (wcnt != slv_wait);
    assign s_if.readdata    = s_if.address ^ KEY;

    always @(posedge clk or posedge rst) begin
        if (rst)
            wcnt <= 0;
        else if ((s_if.read | s_if.write) && s_if.waitrequest)
            wcnt <= wcnt + 1;
        else
            wcnt <= 0;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Completion monitor: pops the scoreboard and tallies per-cycle activity.
    always @(negedge clk) begin
        if (!rst) begin
            if (m0_if.read && !m0_if.write && !m0_if.waitrequest) begin
                chk("q0_avail", 128'(q0.size() > 0), 128'd1);
                if (q0.size() > 0) chk("m0_rdata", m0_if.readdata, q0.pop_front());
            end
            if (m1_if.read && !m1_if.write && !m1_if.waitrequest) begin
                chk("q1_avail", 128'(q1.size() > 0), 128'd1);
                if (q1.size() > 0) chk("m1_rdata", m1_if.readdata, q1.pop_front());
            end
            if (s_if.write && !s_if.waitrequest) begin
                chk("sq_avail", 128'(sq.size() > 0), 128'd1);
                if (sq.size() > 0)
                    chk("s_write", {s_if.address, s_if.writedata, s_if.byteenable}, sq.pop_front());
            end
            if (grant == 2'b01) n_g0++;
            if (grant == 2'b10) begin
                n_g1++;
                if (s_if.write) n_sw++;
                if (m1_if.waitrequest) n_w1++;
                if (!m0_if.waitrequest) n_m0go++;
            end
        end
    end

    task automatic issue(input int m, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be, input bit abrt);
        if (m == 0) begin
            m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
            m0_if.writedata = d; m0_if.byteenable = be;
        end else begin
            m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
            m1_if.writedata = d; m1_if.byteenable = be;
        end
        if (wr) begin
            if (!abrt) sq.push_back({a, d, be});
        end else if (rd) begin
            if (m == 0) q0.push_back(abrt ? 32'h0 : (a ^ KEY));
            else        q1.push_back(abrt ? 32'h0 : (a ^ KEY));
        end
    endtask

    task automatic idle(input int m);
        if (m == 0) begin m0_if.read = 1'b0; m0_if.write = 1'b0; end
        else        begin m1_if.read = 1'b0; m1_if.write = 1'b0; end
    endtask

    // Runs until both masters are idle; a finished master re-reads at address+4 n times.
    task automatic run(input int n0, input int n1, input int max);
        int   cyc;
        logic d0, d1;
        cyc = 0;
        while ((m0_if.read | m0_if.write | m1_if.read | m1_if.write) && cyc < max) begin
            @(negedge clk);
            d0 = (m0_if.read | m0_if.write) && !m0_if.waitrequest;
            d1 = (m1_if.read | m1_if.write) && !m1_if.waitrequest;
            if (d0) begin ord_bits = {ord_bits[14:0], 1'b0}; ord_n++; end
            if (d1) begin ord_bits = {ord_bits[14:0], 1'b1}; ord_n++; end
            @(posedge clk); #1;
            cyc++;
            if (d0) begin
                if (n0 > 0) begin n0--; issue(0, 1'b1, 1'b0, m0_if.address + 32'd4, 32'h0, 4'hF, 1'b0); end
                else idle(0);
            end
            if (d1) begin
                if (n1 > 0) begin n1--; issue(1, 1'b1, 1'b0, m1_if.address + 32'd4, 32'h0, 4'hF, 1'b0); end
                else idle(1);
            end
        end
        chk("run_drained", 128'(m0_if.read | m0_if.write | m1_if.read | m1_if.write), 128'd0);
    endtask

    task automatic clr_stats();
        ord_bits = '0; ord_n = 0;
        n_g0 = 0; n_g1 = 0; n_sw = 0; n_w1 = 0; n_m0go = 0;
    endtask

    initial begin
        rst = 1'b1;
        slv_wait = 0; stuck = 1'b0;
        idle(0); idle(1);
        m0_if.address = '0; m0_if.writedata = '0; m0_if.byteenable = '0;
        m1_if.address = '0; m1_if.writedata = '0; m1_if.byteenable = '0;
        clr_stats();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_berr", bus_error, 1'b0);
        chk("rst_sread", s_if.read, 1'b0);
        chk("rst_m0wait", m0_if.waitrequest, 1'b1);
        chk("rst_m1rdata", m1_if.readdata, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Tie from reset: m0 first, then alternation while both keep requesting.
        clr_stats();
        issue(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 1'b0);
        issue(1, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'hF, 1'b0);
        run(1, 1, 40);
        chk("t2_order", ord_bits, 16'b0101);
        chk("t2_count", ord_n, 4);

        // Lone m0 read: visible to the slave one cycle after the request.
        clr_stats();
        issue(0, 1'b1, 1'b0, 32'hBFC0_0000, 32'h0, 4'hF, 1'b0);
        #1;
        chk("t1_idle_sread", s_if.read, 1'b0);
        chk("t1_idle_grant", grant, 2'b00);
        chk("t1_idle_wait", m0_if.waitrequest, 1'b1);
        @(posedge clk); #1;
        chk("t1_sread", s_if.read, 1'b1);
        chk("t1_saddr", s_if.address, 32'hBFC0_0000);
        chk("t1_grant", grant, 2'b01);
        chk("t1_wait", m0_if.waitrequest, 1'b0);
        chk("t1_rdata", m0_if.readdata, 32'hBFC0_0000 ^ KEY);
        run(0, 0, 20);

        // m1 write with 3 wait states while m0 queues behind it.
        clr_stats();
        slv_wait = 3;
        issue(1, 1'b0, 1'b1, 32'h0000_3000, 32'h0000_00FF, 4'b0001, 1'b0);
        @(posedge clk); #1;
        issue(0, 1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'hF, 1'b0);
        run(0, 0, 40);
        chk("t3_swrite_cycles", n_sw, 4);
        chk("t3_m1_wait_cycles", n_w1, 3);
        chk("t3_m0_released", n_m0go, 0);
        chk("t3_order", ord_bits, 16'b10);

        // Watchdog: stuck slave aborts after 8 owner cycles, error is sticky.
        clr_stats();
        slv_wait = 0; stuck = 1'b1;
        issue(0, 1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'hF, 1'b1);
        run(0, 0, 40);
        chk("t4_own_cycles", n_g0, 8);
        chk("t4_berr", bus_error, 1'b1);
        stuck = 1'b0;
        issue(1, 1'b1, 1'b0, 32'h0000_6000, 32'h0, 4'hF, 1'b0);
        run(0, 0, 20);
        chk("t4_berr_sticky", bus_error, 1'b1);
        chk("t4_after_order", ord_bits, 16'b01);

        // Async reset during an m1 transfer with slave wait.
        clr_stats();
        slv_wait = 5;
        issue(1, 1'b1, 1'b0, 32'h0000_7000, 32'h0, 4'hF, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t5_pre_grant", grant, 2'b10);
        chk("t5_pre_sread", s_if.read, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("t5_grant", grant, 2'b00);
        chk("t5_sread", s_if.read, 1'b0);
        chk("t5_swrite", s_if.write, 1'b0);
        chk("t5_m1wait", m1_if.waitrequest, 1'b1);
        q1.delete();
        idle(1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("t5_berr_cleared", bus_error, 1'b0);
        slv_wait = 0;
        issue(0, 1'b1, 1'b0, 32'h0000_8000, 32'h0, 4'hF, 1'b0);
        issue(1, 1'b1, 1'b0, 32'h0000_9000, 32'h0, 4'hF, 1'b0);
        run(0, 0, 20);
        chk("t5_tie_order", ord_bits, 16'b01);

        // Read and write together: write wins.
        clr_stats();
        slv_wait = 1;
        issue(0, 1'b1, 1'b1, 32'h0000_A000, 32'hDEAD_BEEF, 4'b1100, 1'b0);
        @(posedge clk); #1;
        chk("t6_swrite", s_if.write, 1'b1);
        chk("t6_sread", s_if.read, 1'b0);
        chk("t6_wdata", s_if.writedata, 32'hDEAD_BEEF);
        run(0, 0, 20);

        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);
        chk("sq_empty", sq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
